// File: rtl/byte_deser.sv
// byte_deser: byte-wide deserializer. Collects din_bytecount+1 bytes LSB-first
// into dout and presents the word with a valid/ready handshake.
// Optional build macro BYTE_DESER_TIMEOUT_EN adds an inter-byte gap timeout
// that aborts a stalled reception and raises the sticky err_timeout output.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for recv_begin; incoming bytes are overruns
// RECV  | collecting bytes; remaining counts down to zero
// DONE  | word complete, dout_valid held until dout_ready
module byte_deser #(
   parameter int DATA_W      = 256,
   parameter int CNT_W       = 4,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        din,
   input  logic              din_valid,
   input  logic [CNT_W-1:0]  din_bytecount,
   input  logic              recv_begin,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              busy,
   output logic              err_overrun
`ifdef BYTE_DESER_TIMEOUT_EN
   ,
   output logic              err_timeout
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int OFF_W = $clog2(DATA_W);

   // Parameter sanity: the byte index must always land inside dout.
   if ((DATA_W % 8) != 0 || (1 << CNT_W) > (DATA_W / 8)) begin : g_bad_size
      $error("byte_deser: DATA_W must be a multiple of 8 and hold 2**CNT_W bytes");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("byte_deser: TIMEOUT_CYC must be at least 1");
   end

   state_t            state, next_state;
   logic [CNT_W-1:0]  idx;
   logic [CNT_W:0]    remaining;
   logic [OFF_W-1:0]  bit_off;
   logic              start, take_byte, last_byte, abort;

   assign bit_off   = OFF_W'(idx) << 3;
   assign start     = (state == IDLE) && recv_begin;
   assign take_byte = (state == RECV) && din_valid;
   assign last_byte = take_byte && (remaining == (CNT_W+1)'(1));

`ifdef BYTE_DESER_TIMEOUT_EN
   localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

   logic [GAP_W-1:0] gap_cnt;

   // Idle cycles in RECV count down from TIMEOUT_CYC; the last one aborts.
   assign abort = (state == RECV) && !din_valid && (gap_cnt == GAP_W'(1));

   // Gap down-counter reloads on entry to RECV and on every accepted byte.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gap_cnt     <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (start || take_byte)
            gap_cnt <= GAP_W'(TIMEOUT_CYC);
         else if (state == RECV && gap_cnt != '0)
            gap_cnt <= gap_cnt - 1'b1;
         if (abort)
            err_timeout <= 1'b1;
      end
   end
`else
   assign abort = 1'b0;
`endif

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (recv_begin) next_state = RECV;
         RECV: begin
            if (last_byte)  next_state = DONE;
            else if (abort) next_state = IDLE;
         end
         DONE:    if (dout_ready) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // State register; busy and dout_valid are registered alongside it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         busy       <= 1'b0;
         dout_valid <= 1'b0;
      end else begin
         state      <= next_state;
         busy       <= (next_state != IDLE);
         dout_valid <= (next_state == DONE);
      end
   end

   // Word assembly: clear on arm, place each byte at its index.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dout      <= '0;
         idx       <= '0;
         remaining <= '0;
      end else if (start) begin
         dout      <= '0;
         idx       <= '0;
         remaining <= (CNT_W+1)'(din_bytecount) + 1'b1;
      end else if (abort) begin
         dout      <= '0;
         idx       <= '0;
         remaining <= '0;
      end else if (take_byte) begin
         dout[bit_off +: 8] <= din;
         remaining          <= remaining - 1'b1;
         // Holding idx on the final byte keeps it within 0..2**CNT_W-1.
         if (!last_byte)
            idx <= idx + 1'b1;
      end
   end

   // Sticky overrun: any byte offered outside RECV is dropped and flagged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_overrun <= 1'b0;
      else if (din_valid && state != RECV)
         err_overrun <= 1'b1;
   end

endmodule

// File: tb/tb_byte_deser.sv
// Testbench for byte_deser: directed scenarios plus randomized frames, with a
// scoreboard queue of expected words popped by an independent monitor.
module tb_byte_deser;

   localparam int DATA_W = 256;
   localparam int CNT_W  = 4;
   localparam int TOUT   = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        din;
   logic              din_valid;
   logic [CNT_W-1:0]  din_bytecount;
   logic              recv_begin;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;
   logic              busy;
   logic              err_overrun;
`ifdef BYTE_DESER_TIMEOUT_EN
   logic              err_timeout;
`endif

   byte_deser #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT_CYC(TOUT)) dut (
      .clk(clk),
      .reset(reset),
      .din(din),
      .din_valid(din_valid),
      .din_bytecount(din_bytecount),
      .recv_begin(recv_begin),
      .dout(dout),
      .dout_valid(dout_valid),
      .dout_ready(dout_ready),
      .busy(busy),
      .err_overrun(err_overrun)
`ifdef BYTE_DESER_TIMEOUT_EN
      ,
      .err_timeout(err_timeout)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] sb_q[$];
   logic [7:0]        byte_buf[16];

   task automatic chk(input string name, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: bytes placed LSB-first, everything above them zero.
   function automatic logic [DATA_W-1:0] model_word(input int n);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int i = n - 1; i >= 0; i--)
         w = (w << 8) | DATA_W'(byte_buf[i]);
      return w;
   endfunction

   // Monitor: a handshake will occur at the next rising edge.
   always @(negedge clk) begin
      if (reset && dout_valid && dout_ready) begin
         if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: got %0h expected none", dout);
         end else begin
            chk("sb_word", dout, sb_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int n, input int gapmax, input int hold,
                             input bit mid_begin, input bit done_ovr,
                             input bit begin_on_accept);
      din_bytecount = CNT_W'(n - 1);
      recv_begin    = 1'b1;
      tick();
      recv_begin    = 1'b0;
      din_bytecount = CNT_W'($urandom_range(0, 15));
      sb_q.push_back(model_word(n));
      for (int i = 0; i < n; i++) begin
         int gap = (gapmax > 0) ? $urandom_range(0, gapmax) : 0;
         for (int g = 0; g < gap; g++) tick();
         chk("busy_recv", DATA_W'(busy), 1);
         din       = byte_buf[i];
         din_valid = 1'b1;
         if (mid_begin && i == 1) begin
            recv_begin    = 1'b1;
            din_bytecount = '0;
         end
         tick();
         din_valid  = 1'b0;
         recv_begin = 1'b0;
      end
      chk("valid_latency", DATA_W'(dout_valid), 1);
      chk("busy_done", DATA_W'(busy), 1);
      if (done_ovr) begin
         din       = 8'hAA;
         din_valid = 1'b1;
         tick();
         din_valid = 1'b0;
         chk("ovr_in_done", DATA_W'(err_overrun), 1);
      end
      for (int h = 0; h < hold; h++) begin
         tick();
         chk("valid_held", DATA_W'(dout_valid), 1);
      end
      dout_ready = 1'b1;
      recv_begin = begin_on_accept;
      tick();
      dout_ready = 1'b0;
      recv_begin = 1'b0;
      chk("valid_clr", DATA_W'(dout_valid), 0);
      chk("busy_clr", DATA_W'(busy), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; din = '0; din_valid = 1'b0; din_bytecount = '0;
      recv_begin = 1'b0; dout_ready = 1'b0;
      #12;
      chk("rst_dout", dout, '0);
      chk("rst_valid", DATA_W'(dout_valid), 0);
      chk("rst_busy", DATA_W'(busy), 0);
      chk("rst_ovr", DATA_W'(err_overrun), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Four bytes on consecutive cycles, checked word and upper zeros.
      byte_buf[0] = 8'h11; byte_buf[1] = 8'h22; byte_buf[2] = 8'h33; byte_buf[3] = 8'h44;
      chk("model_4b", model_word(4), DATA_W'(32'h4433_2211));
      send_frame(4, 0, 0, 0, 0, 0);

      // Sixteen bytes with random gaps, ready held low for five cycles.
      for (int i = 0; i < 16; i++) byte_buf[i] = 8'(i);
      send_frame(16, 3, 5, 0, 0, 0);

      // Byte offered in IDLE is dropped and flagged.
      din = 8'hAA; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("ovr_in_idle", DATA_W'(err_overrun), 1);
      chk("idle_no_busy", DATA_W'(busy), 0);

      // Overrun in DONE, recv_begin mid-RECV and on the accept cycle.
      for (int i = 0; i < 16; i++) byte_buf[i] = 8'($urandom_range(0, 255));
      send_frame(6, 2, 2, 1, 1, 1);
      chk("ovr_sticky", DATA_W'(err_overrun), 1);

      // Reset after 2 of 4 bytes: partial word discarded.
      din_bytecount = 4'd3; recv_begin = 1'b1;
      tick();
      recv_begin = 1'b0;
      din = 8'h5A; din_valid = 1'b1; tick();
      din = 8'hA5; tick();
      din_valid = 1'b0;
      reset = 1'b0;
      #1;
      chk("arst_dout", dout, '0);
      chk("arst_valid", DATA_W'(dout_valid), 0);
      chk("arst_busy", DATA_W'(busy), 0);
      chk("arst_ovr", DATA_W'(err_overrun), 0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      byte_buf[0] = 8'hDE; byte_buf[1] = 8'hAD; byte_buf[2] = 8'hBE; byte_buf[3] = 8'hEF;
      send_frame(4, 1, 1, 0, 0, 0);

      // Stalled reception: one byte of two, then TOUT idle cycles.
      din_bytecount = 4'd1; recv_begin = 1'b1;
      tick();
      recv_begin = 1'b0;
      din = 8'h77; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int g = 0; g < TOUT - 1; g++) tick();
      chk("stall_busy_pre", DATA_W'(busy), 1);
      tick();
`ifdef BYTE_DESER_TIMEOUT_EN
      chk("tout_busy", DATA_W'(busy), 0);
      chk("tout_err", DATA_W'(err_timeout), 1);
      chk("tout_valid", DATA_W'(dout_valid), 0);
`else
      chk("stall_busy", DATA_W'(busy), 1);
      chk("stall_valid", DATA_W'(dout_valid), 0);
      byte_buf[0] = 8'h77; byte_buf[1] = 8'h88;
      sb_q.push_back(model_word(2));
      din = 8'h88; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      chk("stall_done", DATA_W'(dout_valid), 1);
      dout_ready = 1'b1;
      tick();
      dout_ready = 1'b0;
`endif

      // Randomized back-to-back frames.
      for (int f = 0; f < 20; f++) begin
         int n = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) byte_buf[i] = 8'($urandom_range(0, 255));
         send_frame(n, $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
      end

      tick();
      chk("sb_drained", DATA_W'(sb_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/byte_deser.md
Name: byte_deser

Overview:
- Byte-wide deserializer; the receive-side counterpart of the CPU byte serializer.
- Collects a programmed number of bytes, LSB-first, into a wide word and presents it with a valid/ready handshake.
- Sits between a byte stream source (bus/UART-style link) and CPU datapath registers; byte order matches the serializer, so a serializer→deserializer loop returns the original word.

Parameters:
- DATA_W, 256, output word width in bits; multiple of 8.
- CNT_W, 4, width of din_bytecount; requires 2^CNT_W ≤ DATA_W/8.
- TIMEOUT_CYC, 255, max idle cycles between bytes (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  8  incoming byte.
- din_valid  in  1  din holds a valid byte this cycle.
- din_bytecount  in  CNT_W  number of bytes to expect, minus one; sampled on recv_begin.
- recv_begin  in  1  arm reception; honoured only in IDLE.
- dout  out  DATA_W  assembled word.
- dout_valid  out  1  dout complete; held until accepted.
- dout_ready  in  1  consumer accepts dout when high with dout_valid.
- busy  out  1  high in RECV or DONE.
- err_overrun  out  1  sticky; a byte arrived while not in RECV.

Behaviour:
- Reset (reset low, async): state=IDLE, dout=0, dout_valid=0, busy=0, err_overrun=0, byte counter=0, remaining=0.
- States: IDLE, RECV, DONE.
- IDLE:
  - recv_begin=1 → RECV next cycle; remaining := din_bytecount+1 (CNT_W+1 bits, range 1..2^CNT_W); byte index := 0; dout cleared to 0.
  - din_valid in IDLE (including the recv_begin cycle) is dropped and sets err_overrun.
- RECV:
  - On each din_valid, din is written to dout[8*idx +: 8]; idx increments; remaining decrements.
  - Untouched upper bytes stay 0.
  - When the last byte is written (remaining 1→0), go to DONE next cycle; dout_valid=1 from that same next cycle. Latency from final byte to dout_valid is 1 cycle.
  - recv_begin ignored.
- DONE:
  - dout and dout_valid are held stable.
  - dout_valid && dout_ready → dout_valid=0, state=IDLE next cycle; dout keeps its value.
  - din_valid in DONE is dropped and sets err_overrun.
  - recv_begin in DONE is ignored, even in the acceptance cycle.
- Back-to-back: a new recv_begin is honoured on the first IDLE cycle after acceptance.
- busy = (state != IDLE), registered with the state.
- err_overrun clears only on reset.
- idx never exceeds 2^CNT_W−1; no wrap-around is possible by construction.
- Reset asserted mid-RECV discards the partial word; no dout_valid is produced.

Optional Feature:
- Macro: BYTE_DESER_TIMEOUT_EN.
- Defined:
  - A gap counter resets on every accepted byte and on entry to RECV.
  - If it reaches TIMEOUT_CYC in RECV with no din_valid, the block aborts to IDLE: partial word discarded, dout_valid not raised.
  - Added output err_timeout (1 bit, sticky, reset to 0) is set on abort.
- Not defined: no gap counter and no err_timeout port; RECV waits indefinitely.

Test Plan:
- Reset, then recv_begin with din_bytecount=3; feed 0x11,0x22,0x33,0x44 on consecutive cycles → dout_valid 1 cycle after 0x44; dout[31:0]=0x44332211, upper bits 0; busy=1 throughout.
- din_bytecount=15, 16 bytes 0x00..0x0F with random gaps in din_valid; hold dout_ready=0 for 5 cycles → dout[127:0]=0x0F0E…0100 stable with dout_valid held; single-cycle ready → IDLE, busy=0.
- din_valid=1 with din=0xAA in IDLE, and again in DONE → byte not captured in dout, err_overrun=1 and stays 1 until reset.
- recv_begin pulsed during RECV with din_bytecount=0 → ignored; the original count completes normally.
- Assert reset after 2 of 4 bytes → all outputs 0 immediately (asynchronously); next recv_begin/4 bytes produces a correct word.
- BYTE_DESER_TIMEOUT_EN with TIMEOUT_CYC=8: 1 byte, then 8 idle cycles → state IDLE, err_timeout=1, dout_valid never asserted; without the macro, same stimulus → remains busy.
